// File: rtl/neuron_mem_arbiter.sv
// neuron_mem_arbiter: shares the single-port neuron-state SRAM between sweep, charge and host with a charge RMW lock
//   CLK, RST                         clock and synchronous active-high reset
//   {sw,ch,host}_req_i/_we_i/_addr_i/_wdata_i   requester access (held until granted)
//   ch_lock_i                        with a charge read: keep the SRAM for the matching write-back
//   {sw,ch,host}_gnt_o               combinational grant, at most one per cycle
//   {sw,ch,host}_rvalid_o, rdata_o   read data, one cycle after a read grant
//   mem_cs_o/we_o/addr_o/wdata_o, mem_rdata_i   SRAM macro port (1-cycle read latency)
//   lock_err_o                       one-cycle pulse when the lock times out
//   NMA_HOST_AGING_EN                optional host aging; undefined gives strict priority
module neuron_mem_arbiter #(
    parameter int N             = 256,
    parameter int DW            = 32,
    parameter int LOCK_TIMEOUT  = 8,
    parameter int HOST_MAX_WAIT = 16,
    localparam int AW           = $clog2(N)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          sw_req_i,
    input  logic          sw_we_i,
    input  logic [AW-1:0] sw_addr_i,
    input  logic [DW-1:0] sw_wdata_i,
    input  logic          ch_req_i,
    input  logic          ch_we_i,
    input  logic [AW-1:0] ch_addr_i,
    input  logic [DW-1:0] ch_wdata_i,
    input  logic          ch_lock_i,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_wdata_i,
    output logic          sw_gnt_o,
    output logic          ch_gnt_o,
    output logic          host_gnt_o,
    output logic          sw_rvalid_o,
    output logic          ch_rvalid_o,
    output logic          host_rvalid_o,
    output logic [DW-1:0] rdata_o,
    output logic          mem_cs_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          lock_err_o
);
    localparam int IW = $clog2(LOCK_TIMEOUT + 1);
    typedef enum logic {ARB, LOCKED} state_t;
    state_t        state, state_nx;
    logic [IW-1:0] idle_cnt;
    logic [2:0]    rv_q;
    logic          timeout, aged;
    assign timeout = state == LOCKED && idle_cnt == IW'(LOCK_TIMEOUT);
`ifdef NMA_HOST_AGING_EN
    localparam int WW = $clog2(HOST_MAX_WAIT + 1);
    logic [WW-1:0] wait_cnt;
    always_ff @(posedge CLK) begin
        if (RST || !host_req_i || host_gnt_o)
            wait_cnt <= '0;
        else if (wait_cnt != WW'(HOST_MAX_WAIT))
            wait_cnt <= wait_cnt + 1'b1;
    end
    assign aged = host_req_i && wait_cnt == WW'(HOST_MAX_WAIT);
`else
    assign aged = 1'b0;
`endif
    always_ff @(posedge CLK) begin
        state <= RST ? ARB : state_nx;
    end
    always_comb begin
        state_nx = state;
        if (state == ARB && ch_gnt_o && !ch_we_i && ch_lock_i)
            state_nx = LOCKED;
        else if (state == LOCKED && (timeout || (ch_gnt_o && ch_we_i)))
            state_nx = ARB;
    end
    // Grants are gated by RST so the SRAM is never touched in a reset cycle.
    always_comb begin
        sw_gnt_o   = 1'b0;
        ch_gnt_o   = 1'b0;
        host_gnt_o = 1'b0;
        lock_err_o = 1'b0;
        if (!RST) begin
            if (state == LOCKED) begin
                lock_err_o = timeout;
                ch_gnt_o   = ch_req_i && !timeout;
            end else if (aged) begin
                host_gnt_o = 1'b1;
            end else begin
                sw_gnt_o   = sw_req_i;
                ch_gnt_o   = ch_req_i && !sw_req_i;
                host_gnt_o = host_req_i && !sw_req_i && !ch_req_i;
            end
        end
    end
    // Idle cycles only accumulate while the lock is held without a charge request.
    always_ff @(posedge CLK) begin
        if (RST || state == ARB || timeout || ch_gnt_o)
            idle_cnt <= '0;
        else if (!ch_req_i)
            idle_cnt <= idle_cnt + 1'b1;
    end
    always_ff @(posedge CLK) begin
        rv_q <= RST ? 3'b0 : {host_gnt_o && !host_we_i, ch_gnt_o && !ch_we_i, sw_gnt_o && !sw_we_i};
    end
    assign sw_rvalid_o   = rv_q[0] && !RST;
    assign ch_rvalid_o   = rv_q[1] && !RST;
    assign host_rvalid_o = rv_q[2] && !RST;
    assign rdata_o       = mem_rdata_i;
    assign mem_cs_o      = sw_gnt_o || ch_gnt_o || host_gnt_o;
    assign mem_we_o      = (sw_gnt_o && sw_we_i) || (ch_gnt_o && ch_we_i) || (host_gnt_o && host_we_i);
    assign mem_addr_o    = ({AW{sw_gnt_o}} & sw_addr_i) | ({AW{ch_gnt_o}} & ch_addr_i) | ({AW{host_gnt_o}} & host_addr_i);
    assign mem_wdata_o   = ({DW{sw_gnt_o}} & sw_wdata_i) | ({DW{ch_gnt_o}} & ch_wdata_i) | ({DW{host_gnt_o}} & host_wdata_i);
endmodule

// File: tb/tb_neuron_mem_arbiter.sv
// tb_neuron_mem_arbiter: directed and randomized checks of neuron_mem_arbiter against a behavioural model
module tb_neuron_mem_arbiter;
    localparam int N = 256, DW = 32, LT = 8, HMW = 16, AW = 8;
`ifdef NMA_HOST_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif
    logic CLK = 1'b0, RST = 1'b1;
    always #5 CLK = ~CLK;
    logic          req [3];
    logic          we  [3];
    logic [AW-1:0] addr[3];
    logic [DW-1:0] wd  [3];
    logic          ch_lock;
    logic sw_gnt, ch_gnt, host_gnt, sw_rv, ch_rv, host_rv, cs, mwe, lerr;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwd, rdata, mrd;
    neuron_mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .sw_req_i(req[0]), .sw_we_i(we[0]), .sw_addr_i(addr[0]), .sw_wdata_i(wd[0]),
        .ch_req_i(req[1]), .ch_we_i(we[1]), .ch_addr_i(addr[1]), .ch_wdata_i(wd[1]), .ch_lock_i(ch_lock),
        .host_req_i(req[2]), .host_we_i(we[2]), .host_addr_i(addr[2]), .host_wdata_i(wd[2]),
        .sw_gnt_o(sw_gnt), .ch_gnt_o(ch_gnt), .host_gnt_o(host_gnt),
        .sw_rvalid_o(sw_rv), .ch_rvalid_o(ch_rv), .host_rvalid_o(host_rv),
        .rdata_o(rdata), .mem_cs_o(cs), .mem_we_o(mwe), .mem_addr_o(maddr),
        .mem_wdata_o(mwd), .mem_rdata_i(mrd), .lock_err_o(lerr)
    );
    function automatic logic [DW-1:0] seed(int i);
        return i == 16 ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
    endfunction
    logic [DW-1:0] sram[N];
    bit seeded = 1'b0;
    always @(posedge CLK) begin
        if (!seeded) begin
            for (int i = 0; i < N; i++) sram[i] <= seed(i);
            seeded <= 1'b1;
        end else if (cs) begin
            if (mwe) sram[maddr] <= mwd;
            else mrd <= sram[maddr];
        end
    end
    logic [DW-1:0] ref_mem[N];
    logic [DW-1:0] exp_rd;
    int locked, idle, waitc, pend, win, vectors, miscompares;
    bit to;
    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cycle();
        int w;
        @(negedge CLK);
        to  = 1'b0;
        win = -1;
        if (!RST) begin
            if (locked != 0) begin
                to = idle == LT;
                if (!to && req[1]) win = 1;
            end else if (AGING && req[2] && waitc == HMW) win = 2;
            else win = req[0] ? 0 : req[1] ? 1 : req[2] ? 2 : -1;
        end
        w = win < 0 ? 0 : win;
        chk("sw_gnt", 32'(sw_gnt), 32'(win == 0));
        chk("ch_gnt", 32'(ch_gnt), 32'(win == 1));
        chk("host_gnt", 32'(host_gnt), 32'(win == 2));
        chk("mem_cs", 32'(cs), 32'(win >= 0));
        chk("mem_we", 32'(mwe), 32'(win >= 0 && we[w]));
        chk("mem_addr", 32'(maddr), win >= 0 ? 32'(addr[w]) : 32'd0);
        chk("mem_wdata", mwd, win >= 0 ? wd[w] : 32'd0);
        chk("lock_err", 32'(lerr), 32'(to));
        chk("sw_rvalid", 32'(sw_rv), 32'(!RST && pend == 0));
        chk("ch_rvalid", 32'(ch_rv), 32'(!RST && pend == 1));
        chk("host_rvalid", 32'(host_rv), 32'(!RST && pend == 2));
        if (!RST && pend >= 0) chk("rdata", rdata, exp_rd);
        @(posedge CLK);
        #1;
        if (RST) begin
            locked = 0; idle = 0; waitc = 0; pend = -1;
        end else begin
            pend = (win >= 0 && !we[w]) ? win : -1;
            if (win >= 0) begin
                if (we[w]) ref_mem[addr[w]] = wd[w];
                else exp_rd = ref_mem[addr[w]];
            end
            if (locked == 0) begin
                if (win == 1 && !we[1] && ch_lock) locked = 1;
                idle = 0;
            end else if (to) begin
                locked = 0; idle = 0;
            end else if (win == 1) begin
                idle = 0;
                if (we[1]) locked = 0;
            end else if (!req[1]) idle++;
            waitc = (!req[2] || win == 2) ? 0 : (waitc < HMW ? waitc + 1 : HMW);
            if (win >= 0) req[w] = 1'b0;
        end
    endtask
    task automatic set(input int r, input logic w_, input int a, input logic [DW-1:0] d);
        req[r] = 1'b1; we[r] = w_; addr[r] = AW'(a); wd[r] = d;
    endtask
    initial begin
        vectors = 0; miscompares = 0; locked = 0; idle = 0; waitc = 0; pend = -1; exp_rd = '0;
        for (int i = 0; i < N; i++) ref_mem[i] = seed(i);
        for (int r = 0; r < 3; r++) begin req[r] = 0; we[r] = 0; addr[r] = '0; wd[r] = '0; end
        ch_lock = 1'b0;
        // all three request during reset, then are served sw, ch, host in order
        set(0, 1'b0, 1, 0); set(1, 1'b0, 2, 0); set(2, 1'b0, 16, 0);
        repeat (2) cycle();
        RST = 1'b0;
        repeat (4) cycle();
        // locked RMW blocks a continuously requesting sweep
        set(1, 1'b0, 5, 0); ch_lock = 1'b1;
        cycle();
        set(0, 1'b1, 7, 32'h1234_5678);
        repeat (3) cycle();
        set(1, 1'b0, 5, 0);
        cycle();
        set(1, 1'b1, 5, 32'hCAFE_0005);
        repeat (3) cycle();
        // lock timeout then sweep wins
        set(1, 1'b0, 6, 0); ch_lock = 1'b1;
        cycle();
        set(0, 1'b0, 6, 0);
        repeat (10) cycle();
        // host against a continuous sweep
        set(2, 1'b0, 3, 0);
        for (int i = 0; i < 20; i++) begin
            set(0, 1'(i & 1), 8 + (i % 4), $urandom);
            cycle();
        end
        req[2] = 1'b0; req[0] = 1'b0;
        cycle();
        // reset right after a locked charge read
        set(1, 1'b0, 9, 0); ch_lock = 1'b1;
        cycle();
        RST = 1'b1;
        set(0, 1'b0, 9, 0);
        cycle();
        RST = 1'b0;
        repeat (2) cycle();
        for (int i = 0; i < 400; i++) begin
            RST = $urandom_range(0, 49) == 0;
            for (int r = 0; r < 3; r++)
                if (!req[r] && $urandom_range(0, 2) == 0) set(r, 1'($urandom), $urandom_range(0, 15), $urandom);
            ch_lock = 1'($urandom);
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
